cfg_bus_arbiter: RTL

- Shares the 4-bit register-configuration bus between two requesters.
  - Port 0: UART-driven address decoder.
  - Port 1: a local initiator, e.g. a power-up default loader.
- Drives the shared bus (address/data/valid) toward the slave modules (clock handler, UART, future VGA timing blocks).
- Receives their OR-combined ack and data_out/data_out_valid.
- Adds round-robin arbitration, a no-ack timeout, and read-back routing to the winning requester.

---
 rtl/cfg_bus_arbiter_if.sv | 27 ++
 rtl/cfg_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter_if.sv
// Shared register-configuration bus between the arbiter and the slave modules.
//   address        : target register address, driven by the arbiter
//   data           : write data, driven by the arbiter
//   valid          : transaction request, driven by the arbiter
//   ack            : OR of slave acknowledges
//   data_out       : OR of slave read-back data
//   data_out_valid : OR of slave read-back valids
// modport master : arbiter side
// modport slave  : slave side (or a bench model of the slaves)
interface cfg_bus_arbiter_if;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [3:0] data_out;
    logic       data_out_valid;

    modport master (
        output address, data, valid,
        input  ack, data_out, data_out_valid
    );

    modport slave (
        input  address, data, valid,
        output ack, data_out, data_out_valid
    );
endinterface

// File: rtl/cfg_bus_arbiter.sv
// Two-port round-robin arbiter for the 4-bit configuration bus.
// Port 0 is the UART address decoder, port 1 a local initiator (e.g. the
// power-up default loader). The winner's address/data are latched onto the
// shared bus until the slaves ack or the no-ack timeout expires; read-back
// data is captured and tagged with the owning requester.
//
// Ports:
//   clk, rst                 system clock, async active-low reset
//   reqN_valid/address/data  requester N transaction request
//   reqN_ack                 one-cycle completion pulse to requester N
//   reqN_timeout             one-cycle abort pulse, coincident with reqN_ack
//   bus                      shared bus, master side
//   rsp_data/valid/owner     captured read-back data, pulse and owner index
//   busy                     high whenever the arbiter is not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free, arbitrating between the two requesters
// WAIT_ACK | bus_valid high, waiting for slave ack or timeout
// RELEASE  | one-cycle gap after completion; requesters drop valid here
module cfg_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [3:0]                req0_address,
    input  logic [3:0]                req0_data,
    output logic                      req0_ack,
    output logic                      req0_timeout,
    input  logic                      req1_valid,
    input  logic [3:0]                req1_address,
    input  logic [3:0]                req1_data,
    output logic                      req1_ack,
    output logic                      req1_timeout,
    cfg_bus_arbiter_if.master         bus,
    output logic [3:0]                rsp_data,
    output logic                      rsp_valid,
    output logic                      rsp_owner,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       addr_q, addr_d;
    logic [3:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       tmo_q, tmo_d;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_owner_q, rsp_owner_d;
    logic             grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ack_q        <= '0;
            tmo_q        <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ack_q        <= ack_d;
            tmo_q        <= tmo_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ack_d        = '0;
        tmo_d        = '0;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = 1'b0;
        rsp_owner_d  = rsp_owner_q;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the port that did not win last time goes next.
                    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    addr_d       = grant ? req1_address : req0_address;
                    data_d       = grant ? req1_data    : req0_data;
                    valid_d      = 1'b1;
                    last_grant_d = grant;
                    cnt_d        = '0;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack on the last allowed cycle still counts as a normal completion.
                if (bus.ack) begin
                    valid_d             = 1'b0;
                    ack_d[last_grant_q] = 1'b1;
                    state_d             = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d             = 1'b0;
                    ack_d[last_grant_q] = 1'b1;
                    tmo_d[last_grant_q] = 1'b1;
                    state_d             = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Read-back is accepted while the owner still holds the bus, including
        // the release cycle right after completion; last_grant_q is the owner.
        if ((state_q == WAIT_ACK || state_q == RELEASE) && bus.data_out_valid) begin
            rsp_data_d  = bus.data_out;
            rsp_valid_d = 1'b1;
            rsp_owner_d = last_grant_q;
        end
    end

    assign bus.address  = addr_q;
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign req0_ack     = ack_q[0];
    assign req1_ack     = ack_q[1];
    assign req0_timeout = tmo_q[0];
    assign req1_timeout = tmo_q[1];
    assign rsp_data     = rsp_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_owner    = rsp_owner_q;
    assign busy         = (state_q != IDLE);

endmodule
